// File: rtl/io_buffer_bank.sv
// io_buffer_bank: word-addressed 1R1W IO data store shared by the cell's
// vector read/write ports and a host valid/ready port. The cell always wins;
// the host is refused (and counted) when it needs a port the cell is using.
// Optional feature macro: IO_BUFFER_BYPASS_EN (write-first forwarding on a
// same-address read/write collision; read-first when undefined).
module io_buffer_bank #(
    parameter int IO_DATA_WIDTH = 256,
    parameter int IO_ADDR_WIDTH = 16,
    parameter int DEPTH         = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     io_en_in,
    input  logic [IO_ADDR_WIDTH-1:0] io_addr_in,
    output logic [IO_DATA_WIDTH-1:0] io_data_in,
    input  logic                     io_en_out,
    input  logic [IO_ADDR_WIDTH-1:0] io_addr_out,
    input  logic [IO_DATA_WIDTH-1:0] io_data_out,
    input  logic                     host_req_valid,
    output logic                     host_req_ready,
    input  logic                     host_req_we,
    input  logic [IO_ADDR_WIDTH-1:0] host_req_addr,
    input  logic [IO_DATA_WIDTH-1:0] host_req_wdata,
    output logic                     host_rsp_valid,
    output logic [IO_DATA_WIDTH-1:0] host_rsp_rdata,
    output logic                     err_oob,
    output logic [15:0]              host_stall_cnt
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // DEPTH may equal 2^IO_ADDR_WIDTH, so compare with one extra bit.
    localparam logic [IO_ADDR_WIDTH:0] DEPTH_EXT = (IO_ADDR_WIDTH + 1)'(DEPTH);

    function automatic logic in_range(input logic [IO_ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_EXT;
    endfunction

    logic [IO_DATA_WIDTH-1:0] mem [DEPTH];

    logic                     host_acc;
    logic                     host_rd;
    logic                     host_wr;
    logic                     rd_en;
    logic                     wr_en;
    logic [IO_ADDR_WIDTH-1:0] rd_addr;
    logic [IO_ADDR_WIDTH-1:0] wr_addr;
    logic [IO_DATA_WIDTH-1:0] wr_data;
    logic                     rd_ok;
    logic                     wr_ok;
    logic [IDX_W-1:0]         rd_idx;
    logic [IDX_W-1:0]         wr_idx;
    logic [IO_DATA_WIDTH-1:0] rd_data;

    logic [IO_DATA_WIDTH-1:0] io_data_in_d,     io_data_in_q;
    logic                     host_rsp_valid_d, host_rsp_valid_q;
    logic [IO_DATA_WIDTH-1:0] host_rsp_rdata_d, host_rsp_rdata_q;
    logic                     err_oob_d,        err_oob_q;
    logic [15:0]              stall_cnt_d,      stall_cnt_q;

    // Port arbitration: cell owns each port when active; host fills the gaps.
    always_comb begin
        host_req_ready = !rst && !(host_req_we ? io_en_out : io_en_in);
        host_acc       = host_req_valid && host_req_ready;
        host_rd        = host_acc && !host_req_we;
        host_wr        = host_acc && host_req_we;
        rd_en          = io_en_in || host_rd;
        rd_addr        = io_en_in ? io_addr_in : host_req_addr;
        wr_en          = io_en_out || host_wr;
        wr_addr        = io_en_out ? io_addr_out : host_req_addr;
        wr_data        = io_en_out ? io_data_out : host_req_wdata;
        rd_ok          = in_range(rd_addr);
        wr_ok          = in_range(wr_addr);
        rd_idx         = rd_addr[IDX_W-1:0];
        wr_idx         = wr_addr[IDX_W-1:0];
    end

    // Read data selection: out-of-range reads return zero and never forward.
    always_comb begin
        rd_data = '0;
        if (rd_ok) begin
`ifdef IO_BUFFER_BYPASS_EN
            if (wr_en && wr_ok && (wr_addr == rd_addr)) begin
                rd_data = wr_data;
            end else begin
                rd_data = mem[rd_idx];
            end
`else
            rd_data = mem[rd_idx];
`endif
        end
    end

    // Next-state for registered outputs and status.
    always_comb begin
        io_data_in_d     = io_en_in ? rd_data : io_data_in_q;
        host_rsp_valid_d = host_rd;
        host_rsp_rdata_d = host_rd ? rd_data : host_rsp_rdata_q;
        err_oob_d        = err_oob_q || (rd_en && !rd_ok) || (wr_en && !wr_ok);
        stall_cnt_d      = stall_cnt_q;
        if (host_req_valid && !host_req_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Storage write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Output and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_data_in_q     <= '0;
            host_rsp_valid_q <= 1'b0;
            host_rsp_rdata_q <= '0;
            err_oob_q        <= 1'b0;
            stall_cnt_q      <= '0;
        end else begin
            io_data_in_q     <= io_data_in_d;
            host_rsp_valid_q <= host_rsp_valid_d;
            host_rsp_rdata_q <= host_rsp_rdata_d;
            err_oob_q        <= err_oob_d;
            stall_cnt_q      <= stall_cnt_d;
        end
    end

    assign io_data_in     = io_data_in_q;
    assign host_rsp_valid = host_rsp_valid_q;
    assign host_rsp_rdata = host_rsp_rdata_q;
    assign err_oob        = err_oob_q;
    assign host_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_io_buffer_bank.sv
// Testbench for io_buffer_bank: queued expectations from a behavioural
// memory model, compared by an independent negedge monitor.
module tb_io_buffer_bank;

    localparam int DEPTH = 1024;
`ifdef IO_BUFFER_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         io_en_in = 1'b0;
    logic [15:0]  io_addr_in = '0;
    logic [255:0] io_data_in;
    logic         io_en_out = 1'b0;
    logic [15:0]  io_addr_out = '0;
    logic [255:0] io_data_out = '0;
    logic         host_req_valid = 1'b0;
    logic         host_req_ready;
    logic         host_req_we = 1'b0;
    logic [15:0]  host_req_addr = '0;
    logic [255:0] host_req_wdata = '0;
    logic         host_rsp_valid;
    logic [255:0] host_rsp_rdata;
    logic         err_oob;
    logic [15:0]  host_stall_cnt;

    io_buffer_bank #(.IO_DATA_WIDTH(256), .IO_ADDR_WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .io_en_in(io_en_in), .io_addr_in(io_addr_in), .io_data_in(io_data_in),
        .io_en_out(io_en_out), .io_addr_out(io_addr_out), .io_data_out(io_data_out),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_we(host_req_we), .host_req_addr(host_req_addr),
        .host_req_wdata(host_req_wdata), .host_rsp_valid(host_rsp_valid),
        .host_rsp_rdata(host_rsp_rdata), .err_oob(err_oob),
        .host_stall_cnt(host_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic         hv;
        logic [255:0] hdata;
        logic [255:0] cdata;
        logic         err;
        logic [15:0]  stall;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    // Behavioural model state
    logic [255:0] m_mem [DEPTH];
    logic [255:0] m_cdata = '0;
    logic [255:0] m_hdata = '0;
    logic         m_err = 1'b0;
    logic [15:0]  m_stall = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Monitor: compare every queued expectation when its cycle arrives
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("due_cycle", 256'(cyc), 256'(e.due));
            chk("host_rsp_valid", {255'b0, host_rsp_valid}, {255'b0, e.hv});
            chk("host_rsp_rdata", host_rsp_rdata, e.hdata);
            chk("io_data_in", io_data_in, e.cdata);
            chk("err_oob", {255'b0, err_oob}, {255'b0, e.err});
            chk("host_stall_cnt", {240'b0, host_stall_cnt}, {240'b0, e.stall});
        end
    end

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [15:0] rnd_addr();
        if ($urandom_range(0, 15) == 0) return 16'($urandom_range(DEPTH, 65535));
        return 16'($urandom_range(0, DEPTH - 1));
    endfunction

    // Drive one cycle, check ready, advance the model, queue the expectation
    task automatic step(input logic r, input logic ce_i, input logic [15:0] ca_i,
                        input logic ce_o, input logic [15:0] ca_o, input logic [255:0] cd_o,
                        input logic hv, input logic hwe, input logic [15:0] ha,
                        input logic [255:0] hwd);
        exp_t         e;
        logic         rdy, hacc, rd, wr, hrd;
        logic [15:0]  ra, wa;
        logic [255:0] wd, rv;
        @(posedge clk);
        #1;
        rst = r; io_en_in = ce_i; io_addr_in = ca_i;
        io_en_out = ce_o; io_addr_out = ca_o; io_data_out = cd_o;
        host_req_valid = hv; host_req_we = hwe; host_req_addr = ha; host_req_wdata = hwd;
        #1;
        rdy = !r && !(hwe ? ce_o : ce_i);
        chk("host_req_ready", {255'b0, host_req_ready}, {255'b0, rdy});
        hrd = 1'b0;
        if (r) begin
            m_cdata = '0; m_hdata = '0; m_err = 1'b0; m_stall = '0;
        end else begin
            hacc = hv && rdy;
            if (hv && !rdy && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            rd = ce_i || (hacc && !hwe);
            ra = ce_i ? ca_i : ha;
            wr = ce_o || (hacc && hwe);
            wa = ce_o ? ca_o : ha;
            wd = ce_o ? cd_o : hwd;
            rv = '0;
            if (rd) begin
                if (32'(ra) >= DEPTH) m_err = 1'b1;
                else if (BYPASS && wr && wa == ra) rv = wd;
                else rv = m_mem[ra[9:0]];
            end
            if (wr) begin
                if (32'(wa) >= DEPTH) m_err = 1'b1;
                else m_mem[wa[9:0]] = wd;
            end
            if (ce_i) m_cdata = rv;
            hrd = hacc && !hwe;
            if (hrd) m_hdata = rv;
        end
        e.due = cyc + 1; e.hv = hrd; e.hdata = m_hdata; e.cdata = m_cdata;
        e.err = m_err; e.stall = m_stall;
        sb.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, '0, 0, 0, 0, '0);
    endtask

    initial begin
        logic [255:0] x, y;
        logic [15:0]  a, b;
        repeat (3) step(1, 0, 0, 0, 0, '0, 0, 0, 0, '0);

        // Cell write 0xA5 word to addr 3, read it back next cycle
        step(0, 0, 0, 1, 16'd3, {32{8'hA5}}, 0, 0, 0, '0);
        step(0, 1, 16'd3, 0, 0, '0, 0, 0, 0, '0);
        idle();

        // Preload every word so all later reads have known contents
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 16'(i), rnd256(), 0, 0, 0, '0);

        // Host write refused while cell writes, then accepted, then read back
        step(0, 0, 0, 1, 16'd100, rnd256(), 1, 1, 16'd7, 256'h1234);
        step(0, 0, 0, 0, 0, '0, 1, 1, 16'd7, 256'h1234);
        step(0, 0, 0, 0, 0, '0, 1, 0, 16'd7, '0);
        idle();

        // Collisions: cell/cell, host-read/cell-write, cell-read/host-write
        x = rnd256(); y = rnd256();
        step(0, 0, 0, 1, 16'd5, x, 0, 0, 0, '0);
        step(0, 1, 16'd5, 1, 16'd5, y, 0, 0, 0, '0);
        idle();
        step(0, 0, 0, 1, 16'd9, rnd256(), 1, 0, 16'd9, '0);
        step(0, 1, 16'd11, 0, 0, '0, 1, 1, 16'd11, rnd256());
        step(0, 1, 16'd11, 0, 0, '0, 0, 0, 0, '0);
        idle();

        // Out of range: cell read DEPTH, host write 2000 must not alias
        step(0, 1, 16'(DEPTH), 0, 0, '0, 0, 0, 0, '0);
        step(0, 0, 0, 0, 0, '0, 1, 1, 16'd2000, rnd256());
        step(0, 0, 0, 0, 0, '0, 1, 0, 16'd976, '0);
        step(0, 1, 16'd976, 0, 0, '0, 0, 0, 0, '0);
        idle();

        // Randomized mix
        for (int i = 0; i < 3000; i++) begin
            logic ci, co, hv, hw;
            a = rnd_addr();
            b = ($urandom_range(0, 3) == 0) ? a : rnd_addr();
            ci = 1'($urandom_range(0, 1));
            co = 1'($urandom_range(0, 1));
            hv = ($urandom_range(0, 9) < 6);
            hw = 1'($urandom_range(0, 1));
            step(0, ci, a, co, b, rnd256(), hv, hw,
                 ($urandom_range(0, 3) == 0) ? (hw ? a : b) : rnd_addr(), rnd256());
        end

        // Stall counter saturation: host read held off by continuous cell reads
        for (int i = 0; i < 70000; i++)
            step(0, 1, 16'($urandom_range(0, DEPTH - 1)), 0, 0, '0, 1, 0, 16'd7, '0);
        idle();

        // Reset asserted with a host read pending, then host accepted again
        step(1, 0, 0, 0, 0, '0, 1, 0, 16'd7, '0);
        step(0, 0, 0, 0, 0, '0, 1, 0, 16'd7, '0);
        idle();
        idle();

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
